tx_framer: RTL and testbench

- Downstream neighbour of the TX cipher stage. Consumes its encrypted 32-bit AXI-Stream (tdata, tvalid, sof) and emits fixed-length frames on an AXI-Stream master with tlast.
- Each frame is one header word, C_PAYLOAD_WORDS payload words, and one CRC-32 trailer word.
- Applies backpressure upstream while it inserts the header and the trailer.

---
 rtl/tx_framer_pkg.sv | 33 +++
 rtl/tx_framer_if.sv | 11 +
 rtl/tx_framer_crc32.sv | 23 ++
 rtl/tx_framer.sv | 150 +++++++++++++++
 tb/tb_tx_framer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_framer_pkg.sv
// Shared types and constants for the TX framer: state encodings, CRC-32 constants, header layout.
// TX_FRAMER_CRC_EN adds the CRC trailer state.
package tx_framer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_HEADER  = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_PAD     = 3'd3;
`ifdef TX_FRAMER_CRC_EN
  localparam state_t ST_CRC     = 3'd4;
`endif

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam int HDR_SYNC_LSB = 16;
  localparam int HDR_SEQ_LSB  = 8;
  localparam int HDR_LEN_LSB  = 0;

  function automatic logic [31:0] make_header(input logic [15:0] sync,
                                              input logic [7:0]  seq,
                                              input logic [7:0]  len);
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 16] = sync;
    h[HDR_SEQ_LSB  +: 8]  = seq;
    h[HDR_LEN_LSB  +: 8]  = len;
    return h;
  endfunction

endpackage

// File: rtl/tx_framer_if.sv
// AXI-Stream style handshake bundle with a start-of-frame sideband, used on both framer sides.
interface tx_framer_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic        sof;

  modport master (output tvalid, output tdata, output tlast, output sof, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input sof, output tready);
endinterface

// File: rtl/tx_framer_crc32.sv
// Combinational CRC-32/BZIP2 step: folds one 32-bit word, MSB first, into the running CRC.
import tx_framer_pkg::*;

module crc32_word (
  input  logic [31:0] i_crc,
  input  logic [31:0] i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;
  logic        w_fb;

  always_comb begin
    w_c  = i_crc;
    w_fb = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      w_fb = w_c[31] ^ i_data[i];
      w_c  = {w_c[30:0], 1'b0} ^ (w_fb ? CRC32_POLY : 32'h0);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/tx_framer.sv
// Fixed-length frame builder: header word, payload (zero-padded if enable drops), optional CRC trailer.
// Build with TX_FRAMER_CRC_EN defined to append the CRC-32 trailer word.
import tx_framer_pkg::*;

// state   | meaning
// IDLE    | waiting for i_enable; loads the header when the output register is free
// HEADER  | header held in the output register until taken downstream
// PAYLOAD | forwarding upstream words into the frame
// PAD     | enable dropped early; filling the rest of the payload with zeros
// CRC     | emitting the inverted CRC as the tlast word (TX_FRAMER_CRC_EN only)
module tx_framer #(
  parameter int          C_PAYLOAD_WORDS = 16,
  parameter logic [15:0] C_SYNC_WORD     = 16'hC20A
) (
  input  logic               i_aclk,
  input  logic               i_aresetn,
  input  logic               i_enable,
  tx_framer_if.slave         s_axis,
  tx_framer_if.master        m_axis,
  output logic [7:0]         o_seq,
  output logic               o_busy,
  output logic               o_sof_error
);

  localparam logic [7:0] C_LEN  = 8'(C_PAYLOAD_WORDS);
  localparam logic [7:0] C_LAST = 8'(C_PAYLOAD_WORDS - 1);

  state_t      r_state;
  logic [7:0]  r_seq;
  logic [7:0]  r_cnt;
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_sof_error;

  logic        w_adv;
  logic        w_s_ready;
  logic        w_s_xfer;
  logic        w_load_word;
  logic        w_last_word;
  logic [31:0] w_word_data;

  assign w_adv       = !r_tvalid || m_axis.tready;
  assign w_s_ready   = (r_state == ST_PAYLOAD) && i_enable && w_adv;
  assign w_s_xfer    = w_s_ready && s_axis.tvalid;
  assign w_load_word = w_s_xfer || ((r_state == ST_PAD) && w_adv);
  assign w_last_word = (r_cnt == C_LAST);
  assign w_word_data = (r_state == ST_PAD) ? 32'h0 : s_axis.tdata;

`ifdef TX_FRAMER_CRC_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_next;

  crc32_word u_crc (
    .i_crc  (r_crc),
    .i_data (w_word_data),
    .o_crc  (w_crc_next)
  );
`endif

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state     <= ST_IDLE;
      r_seq       <= 8'h0;
      r_cnt       <= 8'h0;
      r_tdata     <= 32'h0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_sof_error <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      r_crc       <= CRC32_INIT;
`endif
    end else begin
      // sof is only legal on the first payload word; later ones are still passed as data
      r_sof_error <= w_s_xfer && s_axis.sof && (r_cnt != 8'h0);
      if (w_load_word) begin
        r_tdata  <= w_word_data;
        r_tvalid <= 1'b1;
`ifdef TX_FRAMER_CRC_EN
        r_tlast  <= 1'b0;
        r_crc    <= w_crc_next;
        r_cnt    <= r_cnt + 8'd1;
        if (w_last_word) r_state <= ST_CRC;
`else
        r_tlast  <= w_last_word;
        if (w_last_word) begin
          r_cnt   <= 8'h0;
          r_seq   <= r_seq + 8'd1;
          r_state <= ST_IDLE;
        end else begin
          r_cnt   <= r_cnt + 8'd1;
        end
`endif
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_adv) begin
              if (i_enable) begin
                r_tdata  <= make_header(C_SYNC_WORD, r_seq, C_LEN);
                r_tvalid <= 1'b1;
                r_tlast  <= 1'b0;
                r_state  <= ST_HEADER;
              end else begin
                r_tvalid <= 1'b0;
              end
            end
          end
          ST_HEADER: begin
            if (w_adv) begin
              r_tvalid <= 1'b0;
              r_state  <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            if (w_adv) begin
              r_tvalid <= 1'b0;
              if (!i_enable) r_state <= ST_PAD;
            end
          end
          ST_PAD: begin
          end
`ifdef TX_FRAMER_CRC_EN
          ST_CRC: begin
            if (w_adv) begin
              r_tdata  <= ~r_crc;
              r_tvalid <= 1'b1;
              r_tlast  <= 1'b1;
              r_seq    <= r_seq + 8'd1;
              r_crc    <= CRC32_INIT;
              r_cnt    <= 8'h0;
              r_state  <= ST_IDLE;
            end
          end
`endif
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tlast  = r_tlast;
  assign m_axis.sof    = 1'b0;
  assign o_seq         = r_seq;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_sof_error   = r_sof_error;

endmodule

// File: tb/tb_tx_framer.sv
// Scoreboard bench for tx_framer: expected frames are queued by the stimulus, a monitor pops and compares.
// Honours TX_FRAMER_CRC_EN to match the trailer configuration of the design.
module tb_tx_framer;

  localparam int          C    = 4;
  localparam logic [15:0] SYNC = 16'hC20A;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] seq;
  logic       busy;
  logic       sof_err;

  tx_framer_if s_if ();
  tx_framer_if m_if ();

  tx_framer #(.C_PAYLOAD_WORDS(C), .C_SYNC_WORD(SYNC)) dut (
    .i_aclk      (clk),
    .i_aresetn   (rst_n),
    .i_enable    (en),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_seq       (seq),
    .o_busy      (busy),
    .o_sof_error (sof_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        h;
  } exp_t;

  exp_t        q[$];
  int          checks     = 0;
  int          errors     = 0;
  logic [7:0]  exp_seq    = 8'h0;
  int          sof_cycles = 0;
  bit          rnd_ready  = 1'b0;
  bit          stalled    = 1'b0;
  logic [31:0] st_d;
  logic        st_l;
  bit          bb_mode    = 1'b0;
  bit          hdr_seen   = 1'b0;
  int          gap_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [31:0] w_in);
    logic [31:0] c;
    logic [31:0] w;
    logic        fb;
    c = c_in;
    w = w_in;
    for (int b = 0; b < 32; b++) begin
      fb = c[31] ^ w[31];
      c  = c << 1;
      w  = w << 1;
      if (fb) c = c ^ 32'h04C11DB7;
    end
    return c;
  endfunction

  // Monitor: stall stability, scoreboard pop/compare, sof pulse and gap counting
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(m_if.tvalid), 32'd1);
        chk("stall_data", m_if.tdata, st_d);
        chk("stall_last", 32'(m_if.tlast), 32'(st_l));
      end
      stalled = m_if.tvalid && !m_if.tready;
      st_d    = m_if.tdata;
      st_l    = m_if.tlast;
      if (sof_err) sof_cycles++;
      if (bb_mode && !m_if.tvalid) gap_cnt++;
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected no word", m_if.tdata);
        end else begin
          e = q.pop_front();
          chk("tdata", m_if.tdata, e.d);
          chk("tlast", 32'(m_if.tlast), 32'(e.l));
          if (bb_mode && e.h) begin
            if (hdr_seen) chk("frame_gap_le_1", 32'(gap_cnt <= 1), 32'd1);
            hdr_seen = 1'b1;
            gap_cnt  = 0;
          end
        end
      end
    end
  end

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_frame(input logic [31:0] base, input int n_real);
    logic [31:0] d;
`ifdef TX_FRAMER_CRC_EN
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
`endif
    q.push_back('{d: {SYNC, exp_seq, 8'(C)}, l: 1'b0, h: 1'b1});
    for (int i = 0; i < C; i++) begin
      d = (i < n_real) ? base + 32'(i) : 32'h0;
`ifdef TX_FRAMER_CRC_EN
      crc = crc_model(crc, d);
      q.push_back('{d: d, l: 1'b0, h: 1'b0});
`else
      q.push_back('{d: d, l: (i == C - 1), h: 1'b0});
`endif
    end
`ifdef TX_FRAMER_CRC_EN
    q.push_back('{d: ~crc, l: 1'b1, h: 1'b0});
`endif
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic drive_word(input logic [31:0] d, input logic sof, input bit rnd);
    bit done;
    int t;
    if (rnd) begin
      s_if.tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.sof    = sof;
    done = 1'b0;
    t    = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      done = s_if.tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL input_accept_timeout: got no tready expected accept of %h", d);
    end
    s_if.tvalid = 1'b0;
    s_if.sof    = 1'b0;
  endtask

  task automatic run_frame(input logic [31:0] base, input int n_real, input int sof_idx,
                           input bit rnd, input bit keep_en);
    en = 1'b1;
    push_frame(base, n_real);
    for (int i = 0; i < n_real; i++) drive_word(base + 32'(i), (i == sof_idx), rnd);
    if (!keep_en) en = 1'b0;
  endtask

  task automatic finish_frame(input int sof_exp);
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
    chk("busy_after_frame", 32'(busy), 32'd0);
    chk("o_seq", 32'(seq), 32'(exp_seq));
    chk("sof_error_cycles", 32'(sof_cycles), 32'(sof_exp));
    sof_cycles = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata", m_if.tdata, 32'd0);
    chk("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    chk("rst_o_seq", 32'(seq), 32'd0);
    chk("rst_o_busy", 32'(busy), 32'd0);
    chk("rst_o_sof_error", 32'(sof_err), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    exp_seq     = 8'h0;
    en          = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.sof    = 1'b0;
    sof_cycles  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = 32'h0;
    s_if.sof    = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame 1..4, sof on first word is legal
    run_frame(32'h1, 4, 0, 1'b0, 1'b0);
    finish_frame(0);

    // Enable dropped after two words: zero padding fills the frame
    run_frame(32'hA0, 2, -1, 1'b0, 1'b0);
    finish_frame(0);

    // sof on payload word 3
    run_frame(32'h100, 4, 2, 1'b0, 1'b0);
    finish_frame(1);

    // Random downstream stalls and upstream gaps
    rnd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_frame(32'h5000 + 32'(k * 16), (k == 2) ? 3 : 4, -1, 1'b1, 1'b0);
      finish_frame(0);
    end
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 257 back-to-back frames: header seq wraps 255 -> 0
    pulse_reset();
    bb_mode  = 1'b1;
    hdr_seen = 1'b0;
    gap_cnt  = 0;
    for (int f = 0; f < 257; f++) run_frame(32'(f) << 8, 4, -1, 1'b0, (f != 256));
    finish_frame(0);
    bb_mode = 1'b0;

    // Reset during PAYLOAD discards the frame and clears seq
    en = 1'b1;
    q.push_back('{d: {SYNC, exp_seq, 8'(C)}, l: 1'b0, h: 1'b1});
    q.push_back('{d: 32'hDEAD0000, l: 1'b0, h: 1'b0});
    q.push_back('{d: 32'hDEAD0001, l: 1'b0, h: 1'b0});
    drive_word(32'hDEAD0000, 1'b1, 1'b0);
    drive_word(32'hDEAD0001, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("busy_mid_frame", 32'(busy), 32'd1);
    chk("pre_reset_drain", 32'(q.size()), 32'd0);
    pulse_reset();
    run_frame(32'hBEEF0000, 4, -1, 1'b0, 1'b0);
    finish_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
